delta_engine: RTL and testbench

Parametrised delta-cepstrum engine for the speech front end. Accepts cepstral frames one coefficient per cycle and keeps the last 2K+1 frames in a circular frame buffer. For every centre frame t it sequences the regression d[i] = Σ_{k=1..K} k·(c[t+k][i] − c[t−k][i]) over all NCOEF coefficients and streams the results out with saturation to OUT_W. It replaces the single-step add/sub/shift delta accumulator and sits between the cepstrum register stage and the feature packer.

---
 rtl/delta_pkg.sv | 28 ++
 rtl/delta_frame_buf.sv | 34 +++
 rtl/delta_engine.sv | 253 +++++++++++++++++++++++++
 tb/tb_delta_engine.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delta_pkg.sv
// Shared types and width helpers for the delta-cepstrum engine.
// Widths are derived from IN_W/OUT_W/K so the accumulators never wrap.
package delta_pkg;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_CALC,
    ST_OUT
  } state_e;

  // Number of frames held in the circular buffer.
  function automatic int win_len(input int k);
    return 2 * k + 1;
  endfunction

  function automatic int acc_width(input int in_w, input int k);
    return in_w + 1 + $clog2(k * (k + 1) / 2 + 1);
  endfunction

  function automatic logic signed [63:0] sat_hi(input int out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int out_w);
    return -(64'sd1 <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/delta_frame_buf.sv
// Circular store of the last W cepstral frames: one write port and two
// combinational read ports that fetch c[t+k] and c[t-k] of the same coefficient.
module delta_frame_buf
  import delta_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int NCOEF = 12,
  parameter int W     = 5
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [$clog2(W)-1:0]      wr_slot,
  input  logic [$clog2(NCOEF)-1:0]  wr_col,
  input  logic signed [IN_W-1:0]    wr_data,
  input  logic [$clog2(W)-1:0]      rd_slot_a,
  input  logic [$clog2(W)-1:0]      rd_slot_b,
  input  logic [$clog2(NCOEF)-1:0]  rd_col,
  output logic signed [IN_W-1:0]    rd_data_a,
  output logic signed [IN_W-1:0]    rd_data_b
);

  // Contents are never reset; a restart simply refills before any read matters.
  logic signed [IN_W-1:0] mem_q [W][NCOEF];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_slot][wr_col] <= wr_data;
    end
  end

  assign rd_data_a = mem_q[rd_slot_a][rd_col];
  assign rd_data_b = mem_q[rd_slot_b][rd_col];

endmodule

// File: rtl/delta_engine.sv
// Delta-cepstrum engine: buffers 2K+1 frames and streams saturated regression
// deltas d[i] = sum k*(c[t+k][i]-c[t-k][i]) for the centre frame. reset is active-low.
module delta_engine
  import delta_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 20,
  parameter int NCOEF = 12,
  parameter int K     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [IN_W-1:0]    in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic [$clog2(NCOEF)-1:0]  out_idx,
  output logic                      out_last,
  output logic                      out_sat
);

  localparam int W    = win_len(K);
  localparam int SW   = $clog2(W);
  localparam int CW   = $clog2(NCOEF);
  localparam int KW   = $clog2(K + 1);
  localparam int CNTW = $clog2(W + 1);
  localparam int AW   = acc_width(IN_W, K);
  localparam logic signed [63:0] SAT_HI = sat_hi(OUT_W);
  localparam logic signed [63:0] SAT_LO = sat_lo(OUT_W);

  state_e                   state_q, state_d;
  logic [CW-1:0]            col_q, col_d;
  logic [CW-1:0]            idx_q, idx_d;
  logic [SW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]          count_q, count_d;
  logic [KW-1:0]            k_q, k_d;
  logic [SW-1:0]            slot_a_q, slot_a_d;
  logic [SW-1:0]            slot_b_q, slot_b_d;
  logic                     load_q, load_d;
  logic signed [AW-1:0]     r_q, r_d;
  logic signed [AW-1:0]     a_q, a_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic [CW-1:0]            out_idx_q, out_idx_d;
  logic                     out_last_q, out_last_d;
  logic                     out_sat_q, out_sat_d;

  logic                     buf_we;
  logic signed [IN_W-1:0]   rd_data_a;
  logic signed [IN_W-1:0]   rd_data_b;
  logic [IN_W:0]            diff;
  logic signed [AW-1:0]     diff_ext;
  logic signed [AW-1:0]     r_sum;
  logic signed [AW-1:0]     a_sum;
  logic signed [63:0]       a_wide;
  logic signed [OUT_W-1:0]  sat_val;
  logic                     sat_flag;
  logic [SW-1:0]            newest_slot;
  logic [SW-1:0]            wr_ptr_inc;
  logic [SW-1:0]            slot_a_dec;
  logic [SW-1:0]            slot_b_inc;
  logic [CNTW-1:0]          count_inc;

  assign in_ready = reset & (state_q == ST_FILL);
  assign buf_we   = in_valid & in_ready & ~clear;

  delta_frame_buf #(
    .IN_W  (IN_W),
    .NCOEF (NCOEF),
    .W     (W)
  ) u_frame_buf (
    .clk       (clk),
    .wr_en     (buf_we),
    .wr_slot   (wr_ptr_q),
    .wr_col    (col_q),
    .wr_data   (in_data),
    .rd_slot_a (slot_a_q),
    .rd_slot_b (slot_b_q),
    .rd_col    (idx_q),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  // Modular slot steps by compare-and-wrap; W is not a power of two in general.
  always_comb begin
    newest_slot = (wr_ptr_q == '0) ? SW'(W - 1) : wr_ptr_q - SW'(1);
    wr_ptr_inc  = (wr_ptr_q == SW'(W - 1)) ? '0 : wr_ptr_q + SW'(1);
    slot_a_dec  = (slot_a_q == '0) ? SW'(W - 1) : slot_a_q - SW'(1);
    slot_b_inc  = (slot_b_q == SW'(W - 1)) ? '0 : slot_b_q + SW'(1);
    count_inc   = (count_q == CNTW'(W)) ? count_q : count_q + CNTW'(1);
  end

  // Nested running sums: R collects D_K..D_k, A adds R each step, giving sum k*D_k.
  always_comb begin
    diff     = {rd_data_a[IN_W-1], rd_data_a} - {rd_data_b[IN_W-1], rd_data_b};
    diff_ext = {{(AW - IN_W - 1){diff[IN_W]}}, diff};
    r_sum    = r_q + diff_ext;
    a_sum    = a_q + r_sum;
    a_wide   = {{(64 - AW){a_sum[AW-1]}}, a_sum};
    sat_flag = 1'b0;
    sat_val  = a_wide[OUT_W-1:0];
    if (a_wide > SAT_HI) begin
      sat_val  = SAT_HI[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if (a_wide < SAT_LO) begin
      sat_val  = SAT_LO[OUT_W-1:0];
      sat_flag = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    idx_d       = idx_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    k_d         = k_q;
    slot_a_d    = slot_a_q;
    slot_b_d    = slot_b_q;
    load_d      = load_q;
    r_d         = r_q;
    a_d         = a_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_sat_d   = out_sat_q;

    if (clear) begin
      state_d     = ST_FILL;
      col_d       = '0;
      idx_d       = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      load_d      = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_FILL: begin
          if (in_valid) begin
            if (col_q == CW'(NCOEF - 1)) begin
              col_d    = '0;
              wr_ptr_d = wr_ptr_inc;
              count_d  = count_inc;
              if (count_inc == CNTW'(W)) begin
                state_d = ST_CALC;
                idx_d   = '0;
                load_d  = 1'b1;
              end
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end

        ST_CALC: begin
          if (load_q) begin
            // wr_ptr has settled: it now names the oldest frame (t-K).
            load_d   = 1'b0;
            slot_a_d = newest_slot;
            slot_b_d = wr_ptr_q;
            k_d      = KW'(K);
            r_d      = '0;
            a_d      = '0;
          end else begin
            r_d      = r_sum;
            a_d      = a_sum;
            slot_a_d = slot_a_dec;
            slot_b_d = slot_b_inc;
            k_d      = k_q - KW'(1);
            if (k_q == KW'(1)) begin
              state_d     = ST_OUT;
              out_valid_d = 1'b1;
              out_data_d  = sat_val;
              out_sat_d   = sat_flag;
              out_idx_d   = idx_q;
              out_last_d  = (idx_q == CW'(NCOEF - 1));
            end
          end
        end

        ST_OUT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
              state_d = ST_FILL;
            end else begin
              state_d  = ST_CALC;
              idx_d    = idx_q + CW'(1);
              slot_a_d = newest_slot;
              slot_b_d = wr_ptr_q;
              k_d      = KW'(K);
              r_d      = '0;
              a_d      = '0;
            end
          end
        end

        default: begin
          state_d = ST_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_FILL;
      col_q       <= '0;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      k_q         <= '0;
      slot_a_q    <= '0;
      slot_b_q    <= '0;
      load_q      <= 1'b0;
      r_q         <= '0;
      a_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      k_q         <= k_d;
      slot_a_q    <= slot_a_d;
      slot_b_q    <= slot_b_d;
      load_q      <= load_d;
      r_q         <= r_d;
      a_q         <= a_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_delta_engine.sv
// Directed bench for delta_engine (IN_W=16, OUT_W=18, NCOEF=3, K=2):
// table of frames with hand-computed deltas, plus fill/backpressure/clear/reset sequences.
module tb_delta_engine;

  localparam int IN_W  = 16;
  localparam int OUT_W = 18;
  localparam int NCOEF = 3;
  localparam int K     = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset;
  logic                     clear;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [IN_W-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic [1:0]               out_idx;
  logic                     out_last;
  logic                     out_sat;

  delta_engine #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .NCOEF (NCOEF),
    .K     (K)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_sat   (out_sat)
  );

  typedef struct {
    bit                      clr;
    logic signed [IN_W-1:0]  c0, c1, c2;
    bit                      has_out;
    logic signed [OUT_W-1:0] e0, e1, e2;
    bit                      s0, s1, s2;
  } vec_t;

  typedef struct {
    logic signed [OUT_W-1:0] data;
    int                      idx;
    bit                      last;
    bit                      sat;
  } beat_t;

  beat_t beat_q[$];
  int    valid_cycles;
  int    n_pass;
  int    n_total;
  vec_t  vecs[12];

  // Sampled mid-cycle: these are the values the next rising edge will act on.
  always @(negedge clk) begin
    if (out_valid) valid_cycles++;
    if (out_valid && out_ready) begin
      beat_t b;
      b.data = out_data;
      b.idx  = int'(out_idx);
      b.last = out_last;
      b.sat  = out_sat;
      beat_q.push_back(b);
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic vec_t mk(input bit clr, input int c0, input int c1, input int c2,
                              input bit has_out, input int e0, input int e1, input int e2,
                              input bit s0, input bit s1, input bit s2);
    vec_t v;
    v.clr = clr;
    v.c0 = c0[IN_W-1:0]; v.c1 = c1[IN_W-1:0]; v.c2 = c2[IN_W-1:0];
    v.has_out = has_out;
    v.e0 = e0[OUT_W-1:0]; v.e1 = e1[OUT_W-1:0]; v.e2 = e2[OUT_W-1:0];
    v.s0 = s0; v.s1 = s1; v.s2 = s2;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic signed [IN_W-1:0] v);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) chk("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int c0, input int c1, input int c2);
    send_beat(c0[IN_W-1:0]);
    send_beat(c1[IN_W-1:0]);
    send_beat(c2[IN_W-1:0]);
  endtask

  task automatic send_ramp(input int f);
    send_frame(10 * f, 10 * f + 1, 10 * f + 2);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int t;
    t = 0;
    while (beat_q.size() < n && t < 500) begin
      tick();
      t++;
    end
    chk("beat_count", beat_q.size(), n);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!out_valid && t < 100) begin
      tick();
      t++;
    end
    chk("valid_timeout", out_valid, 1);
  endtask

  task automatic pop_check(input string tag, input int exp_idx, input longint exp_data,
                           input bit exp_sat);
    beat_t b;
    if (beat_q.size() == 0) begin
      chk({tag, "_missing"}, 0, 1);
      return;
    end
    b = beat_q.pop_front();
    $display("beat %s idx=%0d data=%0d last=%0d sat=%0d", tag, b.idx, b.data, b.last, b.sat);
    chk({tag, "_idx"}, b.idx, exp_idx);
    chk({tag, "_data"}, longint'(b.data), exp_data);
    chk({tag, "_last"}, b.last, exp_idx == NCOEF - 1);
    chk({tag, "_sat"}, b.sat, exp_sat);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    valid_cycles = 0;
    reset = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;

    // Ramp c[f][i] = 10f+i: every delta is 1*20 + 2*40 = 100.
    for (int f = 0; f < 7; f++)
      vecs[f] = mk(0, 10 * f, 10 * f + 1, 10 * f + 2, f >= 4, 100, 100, 100, 0, 0, 0);
    // Coeff 0: +3*65535 clips high; coeff 1: clips low; coeff 2: 1*(4-2)+2*(8-1) = 16.
    vecs[7]  = mk(1, -32768,  32767, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, -32768,  32767, 2, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0,      0,      0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(0,  32767, -32768, 4, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0,  32767, -32768, 8, 1, 131071, -131072, 16, 1, 1, 0);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_sat", out_sat, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    tick();

    // Table: ramp then saturation
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].clr) do_clear();
      send_frame(vecs[v].c0, vecs[v].c1, vecs[v].c2);
      if (vecs[v].has_out) begin
        wait_beats(3);
        pop_check($sformatf("vec%0d_b0", v), 0, longint'(vecs[v].e0), vecs[v].s0);
        pop_check($sformatf("vec%0d_b1", v), 1, longint'(vecs[v].e1), vecs[v].s1);
        pop_check($sformatf("vec%0d_b2", v), 2, longint'(vecs[v].e2), vecs[v].s2);
      end
    end
    repeat (10) tick();
    chk("table_extra_beats", beat_q.size(), 0);

    // Fill boundary: four frames give nothing, fifth gives out_valid K+1 edges later
    do_clear();
    beat_q.delete();
    out_ready = 1'b0;
    valid_cycles = 0;
    for (int f = 0; f < 4; f++) send_ramp(f);
    repeat (10) tick();
    chk("fill_no_valid", valid_cycles, 0);
    send_beat(16'sd40);
    send_beat(16'sd41);
    in_valid = 1'b1;
    in_data = 16'sd42;
    tick();
    in_valid = 1'b0;
    chk("ready_drop", in_ready, 0);
    chk("lat_c0", out_valid, 0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("lat_c%0d", c), out_valid, c == 3);
    end
    chk("lat_idx", out_idx, 0);
    chk("lat_data", longint'(out_data), 100);

    // Backpressure on idx 1
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_valid();
    chk("bp_idx_first", out_idx, 1);
    for (int c = 0; c < 7; c++) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_idx", out_idx, 1);
      chk("bp_data", longint'(out_data), 100);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    wait_beats(3);
    repeat (10) tick();
    chk("bp_beat_total", beat_q.size(), 3);
    for (int b = 0; b < 3; b++) pop_check($sformatf("bp_b%0d", b), b, 100, 0);

    // Clear while idx 1 is waiting
    out_ready = 1'b0;
    send_ramp(5);
    wait_valid();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_valid();
    chk("clr_pre_idx", out_idx, 1);
    do_clear();
    chk("clr_out_valid", out_valid, 0);
    chk("clr_in_ready", in_ready, 1);
    out_ready = 1'b1;
    beat_q.delete();
    valid_cycles = 0;
    for (int f = 0; f < 4; f++) send_ramp(f);
    repeat (10) tick();
    chk("clr_no_valid", valid_cycles, 0);
    send_ramp(4);
    wait_beats(3);
    for (int b = 0; b < 3; b++) pop_check($sformatf("clr_b%0d", b), b, 100, 0);

    // Asynchronous reset in the middle of CALC
    send_ramp(5);
    tick();
    reset = 1'b0;
    #1;
    chk("areset_in_ready", in_ready, 0);
    chk("areset_out_valid", out_valid, 0);
    chk("areset_out_data", out_data, 0);
    chk("areset_out_idx", out_idx, 0);
    chk("areset_out_last", out_last, 0);
    chk("areset_out_sat", out_sat, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("areset_rel_ready", in_ready, 1);
    beat_q.delete();
    for (int f = 0; f < 7; f++) send_ramp(f);
    wait_beats(9);
    for (int b = 0; b < 9; b++) pop_check($sformatf("refill_b%0d", b), b % 3, 100, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
